// File: rtl/deserializer.sv
// rtl/deserializer.sv - MSB-first serial-to-parallel word assembler with runt drop
//
// Collects a serial bit stream into WIDTH-bit words, MSB first. A full word is
// emitted every WIDTH valid bits. When a burst ends early, the bits collected so
// far are emitted as a left-aligned partial word with its bit count. Tails shorter
// than MIN_LEN are discarded and flagged on drop_o instead.
//
// Ports:
//   clk_i             clock
//   srst_i            asynchronous active-high reset
//   ser_data_i        serial data bit, MSB of each word first
//   ser_data_val_i    qualifies ser_data_i; a burst is a contiguous run of valid cycles
//   deser_data_o      assembled word, left-aligned, unused low bits zero
//   deser_data_mod_o  number of valid bits, 0 meaning a full WIDTH-bit word
//   deser_data_val_o  one-cycle pulse qualifying deser_data_o / deser_data_mod_o
//   drop_o            one-cycle pulse: a runt tail of 1..MIN_LEN-1 bits was discarded

module deserializer #(
  parameter int WIDTH   = 16,
  parameter int MOD_W   = $clog2(WIDTH),
  parameter int MIN_LEN = 3
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             ser_data_i,
  input  logic             ser_data_val_i,
  output logic [WIDTH-1:0] deser_data_o,
  output logic [MOD_W-1:0] deser_data_mod_o,
  output logic             deser_data_val_o,
  output logic             drop_o
);

  localparam logic [MOD_W:0] CNT_LAST = (MOD_W+1)'(WIDTH - 1);
  localparam logic [MOD_W:0] CNT_MIN  = (MOD_W+1)'(MIN_LEN);
  localparam logic [MOD_W:0] CNT_ONE  = (MOD_W+1)'(1);

  logic [WIDTH-1:0] r_sh;
  logic [MOD_W:0]   r_cnt;
  logic [WIDTH-1:0] r_data;
  logic [MOD_W-1:0] r_mod;
  logic             r_val;
  logic             r_drop;

  logic [MOD_W-1:0] w_idx;
  logic [WIDTH-1:0] w_sh_new;

  // WIDTH is a power of two, so WIDTH-1-cnt is the bitwise inverse of the low
  // MOD_W bits of the counter.
  assign w_idx = ~r_cnt[MOD_W-1:0];

  // Shift register with the incoming bit placed at its MSB-first position.
  always_comb begin
    w_sh_new        = r_sh;
    w_sh_new[w_idx] = ser_data_i;
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_mod  <= '0;
      r_val  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_val  <= 1'b0;
      r_drop <= 1'b0;
      if (ser_data_val_i) begin
        if (r_cnt == CNT_LAST) begin
          // Last bit of a word: emit directly from the updated shift value so
          // long bursts need no idle gap between words.
          r_data <= w_sh_new;
          r_mod  <= '0;
          r_val  <= 1'b1;
          r_cnt  <= '0;
          r_sh   <= '0;
        end else begin
          r_sh  <= w_sh_new;
          r_cnt <= r_cnt + CNT_ONE;
        end
      end else begin
        // Burst end: flush a long enough tail, flag a runt, ignore an empty one.
        if (r_cnt >= CNT_MIN) begin
          r_data <= r_sh;
          r_mod  <= r_cnt[MOD_W-1:0];
          r_val  <= 1'b1;
        end else if (r_cnt != '0) begin
          r_drop <= 1'b1;
        end
        r_cnt <= '0;
        r_sh  <= '0;
      end
    end
  end

  assign deser_data_o     = r_data;
  assign deser_data_mod_o = r_mod;
  assign deser_data_val_o = r_val;
  assign drop_o           = r_drop;

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed self-checking bench for deserializer

module tb_deserializer;

  logic        clk;
  logic        srst;
  logic        ser_dat;
  logic        ser_val;
  logic [15:0] data;
  logic [3:0]  mod;
  logic        dval;
  logic        drop;

  int total;
  int bad;

  deserializer #(.WIDTH(16), .MOD_W(4), .MIN_LEN(3)) dut (
    .clk_i            (clk),
    .srst_i           (srst),
    .ser_data_i       (ser_dat),
    .ser_data_val_i   (ser_val),
    .deser_data_o     (data),
    .deser_data_mod_o (mod),
    .deser_data_val_o (dval),
    .drop_o           (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic b);
    ser_val = v;
    ser_dat = b;
    @(posedge clk);
    #1;
  endtask

  // Sends a 16-bit word MSB first; no output pulse may appear before the last bit.
  task automatic send_word(input string tag, input logic [15:0] w);
    for (int i = 15; i >= 0; i--) begin
      step(1'b1, w[i]);
      if (i > 0) check({tag, "_noval"}, {31'd0, dval}, 32'd0);
      check({tag, "_nodrop"}, {31'd0, drop}, 32'd0);
    end
  endtask

  initial begin
    int t1;
    int t2;
    logic [4:0] b5;
    logic [3:0] b4;
    logic [2:0] b3;
    total   = 0;
    bad     = 0;
    srst    = 1'b1;
    ser_dat = 1'b0;
    ser_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", {16'd0, data}, 32'd0);
    check("rst_mod",  {28'd0, mod},  32'd0);
    check("rst_val",  {31'd0, dval}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    srst = 1'b0;
    step(1'b0, 1'b0);
    check("idle_val",  {31'd0, dval}, 32'd0);
    check("idle_drop", {31'd0, drop}, 32'd0);

    // Full word 0xA5C3
    send_word("w_a5c3", 16'hA5C3);
    check("a5c3_val",  {31'd0, dval}, 32'd1);
    check("a5c3_data", {16'd0, data}, 32'h0000A5C3);
    check("a5c3_mod",  {28'd0, mod},  32'd0);
    step(1'b0, 1'b0);
    check("a5c3_end_val",  {31'd0, dval}, 32'd0);
    check("a5c3_end_drop", {31'd0, drop}, 32'd0);
    check("a5c3_hold",     {16'd0, data}, 32'h0000A5C3);

    // 5-bit partial 1,0,1,1,0
    b5 = 5'b10110;
    for (int i = 4; i >= 0; i--) step(1'b1, b5[i]);
    check("p5_early_val", {31'd0, dval}, 32'd0);
    step(1'b0, 1'b1);
    check("p5_val",  {31'd0, dval}, 32'd1);
    check("p5_data", {16'd0, data}, 32'h0000B000);
    check("p5_mod",  {28'd0, mod},  32'd5);
    check("p5_drop", {31'd0, drop}, 32'd0);
    step(1'b0, 1'b0);
    check("p5_after_val", {31'd0, dval}, 32'd0);
    check("p5_hold_mod",  {28'd0, mod},  32'd5);

    // 2-bit runt then a full word
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("runt_drop", {31'd0, drop}, 32'd1);
    check("runt_val",  {31'd0, dval}, 32'd0);
    step(1'b0, 1'b0);
    check("runt_drop_clr", {31'd0, drop}, 32'd0);
    send_word("w_1234", 16'h1234);
    check("w1234_val",  {31'd0, dval}, 32'd1);
    check("w1234_data", {16'd0, data}, 32'h00001234);
    check("w1234_mod",  {28'd0, mod},  32'd0);
    step(1'b0, 1'b0);

    // 36-bit burst: 0xFFFF, 0x0001, 1010
    send_word("w_ffff", 16'hFFFF);
    check("ffff_val",  {31'd0, dval}, 32'd1);
    check("ffff_data", {16'd0, data}, 32'h0000FFFF);
    check("ffff_mod",  {28'd0, mod},  32'd0);
    t1 = $time;
    send_word("w_0001", 16'h0001);
    check("0001_val",  {31'd0, dval}, 32'd1);
    check("0001_data", {16'd0, data}, 32'h00000001);
    check("0001_mod",  {28'd0, mod},  32'd0);
    t2 = $time;
    check("word_spacing", t2 - t1, 32'd160);
    b4 = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, b4[i]);
      check("tail_noval", {31'd0, dval}, 32'd0);
    end
    step(1'b0, 1'b0);
    check("tail_val",  {31'd0, dval}, 32'd1);
    check("tail_data", {16'd0, data}, 32'h0000A000);
    check("tail_mod",  {28'd0, mod},  32'd4);

    // Asynchronous reset after 7 bits of a word
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    #2;
    srst = 1'b1;
    #1;
    check("arst_data", {16'd0, data}, 32'd0);
    check("arst_mod",  {28'd0, mod},  32'd0);
    check("arst_val",  {31'd0, dval}, 32'd0);
    check("arst_drop", {31'd0, drop}, 32'd0);
    ser_val = 1'b0;
    @(posedge clk);
    #1;
    srst = 1'b0;
    step(1'b0, 1'b0);
    check("arst_nopulse", {30'd0, dval, drop}, 32'd0);
    send_word("w_8001", 16'h8001);
    check("w8001_val",  {31'd0, dval}, 32'd1);
    check("w8001_data", {16'd0, data}, 32'h00008001);
    check("w8001_mod",  {28'd0, mod},  32'd0);
    step(1'b0, 1'b0);

    // Alternating single-bit bursts
    b3 = 3'b101;
    for (int i = 2; i >= 0; i--) begin
      step(1'b1, b3[i]);
      check("alt_bit_val", {31'd0, dval}, 32'd0);
      step(1'b0, 1'b0);
      check("alt_drop", {31'd0, drop}, 32'd1);
      check("alt_val",  {31'd0, dval}, 32'd0);
    end
    step(1'b0, 1'b0);
    check("alt_final_drop", {31'd0, drop}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
